// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART control blocks.
package uart_ctrl_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int TIMEOUT_CYC_DEF = 64;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ISSUE      = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo N. Returns one-hot grant, binary index and valid.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_valid
);

   always_comb begin
      logic [PW:0] w_pos;
      logic        w_found;
      w_pos   = '0;
      w_found = 1'b0;
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         // i_ptr is always < N, so one subtraction wraps the sum
         w_pos = {1'b0, i_ptr} + (PW+1)'(i);
         if (w_pos >= (PW+1)'(N)) begin
            w_pos = w_pos - (PW+1)'(N);
         end
         if (!w_found && i_req[w_pos[PW-1:0]]) begin
            w_found              = 1'b1;
            o_grant[w_pos[PW-1:0]] = 1'b1;
            o_idx                = w_pos[PW-1:0];
         end
      end
      o_valid = w_found;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Define TX_ARB_TIMEOUT_EN to add a watchdog that retires stuck bytes via err.
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int PTR_W       = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*8-1:0]       req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [NUM_REQ-1:0]         done,
   output logic [NUM_REQ-1:0]         err,
   output logic [UART_DATA_W-1:0]     tx_data,
   output logic                       tx_en,
   input  logic                       tx_done,
   output logic                       busy,
   output logic [PTR_W-1:0]           owner
);

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be 2..16");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT_CYC must be >= 2");
   end

   arb_state_t              r_state;
   logic [PTR_W-1:0]        r_ptr;
   logic [PTR_W-1:0]        r_owner;
   logic [NUM_REQ-1:0]      r_ack;
   logic [NUM_REQ-1:0]      r_done;
   logic [UART_DATA_W-1:0]  r_tx_data;
   logic                    r_tx_en;
   logic                    r_busy;

   logic [NUM_REQ-1:0]      w_grant;
   logic [PTR_W-1:0]        w_idx;
   logic                    w_valid;
   logic [PTR_W-1:0]        w_ptr_nxt;

   rr_pick #(
      .N  (NUM_REQ),
      .PW (PTR_W)
   ) u_pick (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   assign w_ptr_nxt = (r_owner == PTR_W'(NUM_REQ - 1)) ? '0
                                                       : r_owner + 1'b1;

`ifdef TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   logic [NUM_REQ-1:0] r_err;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_expired;

   assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign err       = r_err;
`else
   assign err = '0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_owner   <= '0;
         r_ack     <= '0;
         r_done    <= '0;
         r_tx_data <= '0;
         r_tx_en   <= 1'b0;
         r_busy    <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
         r_err     <= '0;
         r_cnt     <= '0;
`endif
      end else begin
         r_ack   <= '0;
         r_done  <= '0;
         r_tx_en <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
         r_err   <= '0;
`endif
         unique case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_tx_data <= req_data[w_idx*UART_DATA_W +: UART_DATA_W];
                  r_ack     <= w_grant;
                  r_owner   <= w_idx;
                  r_busy    <= 1'b1;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_tx_en <= 1'b1;
               r_state <= WAIT_START;
`ifdef TX_ARB_TIMEOUT_EN
               r_cnt   <= '0;
`endif
            end
            WAIT_START: begin
`ifdef TX_ARB_TIMEOUT_EN
               if (w_expired) begin
                  r_err[r_owner] <= 1'b1;
                  r_ptr          <= w_ptr_nxt;
                  r_busy         <= 1'b0;
                  r_state        <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (!tx_done) begin
                     r_state <= WAIT_DONE;
                  end
               end
`else
               if (!tx_done) begin
                  r_state <= WAIT_DONE;
               end
`endif
            end
            WAIT_DONE: begin
               // completion wins over a same-cycle watchdog expiry
               if (tx_done) begin
                  r_done[r_owner] <= 1'b1;
                  r_ptr           <= w_ptr_nxt;
                  r_busy          <= 1'b0;
                  r_state         <= IDLE;
               end
`ifdef TX_ARB_TIMEOUT_EN
               else if (w_expired) begin
                  r_err[r_owner] <= 1'b1;
                  r_ptr          <= w_ptr_nxt;
                  r_busy         <= 1'b0;
                  r_state        <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ack     = r_ack;
   assign done    = r_done;
   assign tx_data = r_tx_data;
   assign tx_en   = r_tx_en;
   assign busy    = r_busy;
   assign owner   = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model.
// Timeout steps run only when TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

`ifdef TX_ARB_TIMEOUT_EN
   localparam int TCYC = 16;
`else
   localparam int TCYC = 64;
`endif

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic [3:0]  done;
   logic [3:0]  err;
   logic [7:0]  tx_data;
   logic        tx_en;
   logic        tx_done;
   logic        busy;
   logic [1:0]  owner;

   int n_cmp;
   int n_err;
   bit m_stuck;

   uart_tx_arbiter #(
      .NUM_REQ     (4),
      .TIMEOUT_CYC (TCYC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .done     (done),
      .err      (err),
      .tx_data  (tx_data),
      .tx_en    (tx_en),
      .tx_done  (tx_done),
      .busy     (busy),
      .owner    (owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // transmitter: tx_done falls 2 cycles after tx_en, rises 10 cycles later
   initial begin
      tx_done = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_en === 1'b1) begin
            repeat (2) @(negedge clk);
            if (!m_stuck) tx_done = 1'b0;
            repeat (10) @(negedge clk);
            tx_done = 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input string tag, input logic [3:0] e_ack,
                           input logic [7:0] e_data, input logic [1:0] e_own);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack !== 4'b0) break;
      end
      chk({tag, "_ack"}, 32'(ack), 32'(e_ack));
      chk({tag, "_data"}, 32'(tx_data), 32'(e_data));
      chk({tag, "_owner"}, 32'(owner), 32'(e_own));
   endtask

   task automatic wait_done(input string tag, input logic [3:0] e_done);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done !== 4'b0 || err !== 4'b0) break;
      end
      chk({tag, "_done"}, 32'(done), 32'(e_done));
      chk({tag, "_err"}, 32'(err), 32'h0);
      chk({tag, "_gap"}, 32'(ack), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ack"}, 32'(ack), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h0);
      chk({tag, "_err"}, 32'(err), 32'h0);
      chk({tag, "_txd"}, 32'(tx_data), 32'h0);
      chk({tag, "_txen"}, 32'(tx_en), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_owner"}, 32'(owner), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int         n;
      logic [3:0] acc;
      n_cmp    = 0;
      n_err    = 0;
      m_stuck  = 1'b0;
      rst_n    = 1'b0;
      req      = 4'b0;
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // contention: all four hold requests, ptr starts at 0
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack("cont", 4'b0001 << (k % 4), 8'h10 + 8'(k % 4), 2'(k % 4));
         if (k == 4) req = 4'b0;
         wait_done("cont", 4'b0001 << (k % 4));
      end

      // single request, exact timing (ptr=1 -> requester 2)
      req_data[23:16] = 8'hA5;
      req = 4'b0100;
      @(negedge clk);
      chk("single_ack", 32'(ack), 32'h4);
      chk("single_en0", 32'(tx_en), 32'h0);
      chk("single_busy", 32'(busy), 32'h1);
      chk("single_owner", 32'(owner), 32'h2);
      chk("single_data", 32'(tx_data), 32'hA5);
      req = 4'b0;
      @(negedge clk);
      chk("single_en1", 32'(tx_en), 32'h1);
      chk("single_ack0", 32'(ack), 32'h0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (done !== 4'b0) break;
      end
      chk("single_lat", 32'(n), 32'd13);
      chk("single_done", 32'(done), 32'h4);
      chk("single_busy0", 32'(busy), 32'h0);
      chk("single_hold", 32'(tx_data), 32'hA5);
      req_data[23:16] = 8'h12;

      // pointer wrap: ptr=3, req 0 and 1 -> 0 first
      req = 4'b0011;
      wait_ack("wrap0", 4'b0001, 8'h10, 2'd0);
      req = 4'b0010;
      wait_done("wrap0", 4'b0001);
      wait_ack("wrap1", 4'b0010, 8'h11, 2'd1);
      req = 4'b0;
      wait_done("wrap1", 4'b0010);

      // withdrawal: req[1] pulsed while requester 0 is busy
      req = 4'b0001;
      wait_ack("wd", 4'b0001, 8'h10, 2'd0);
      req = 4'b0;
      repeat (3) @(negedge clk);
      req = 4'b0010;
      @(negedge clk);
      req = 4'b0;
      wait_done("wd", 4'b0001);
      acc = 4'b0;
      repeat (6) begin
         @(negedge clk);
         acc = acc | ack;
      end
      chk("wd_noack", 32'(acc), 32'h0);
      chk("wd_idle", 32'(busy), 32'h0);

      // reset during WAIT_DONE (ptr=1 beforehand)
      req = 4'b1000;
      wait_ack("rst", 4'b1000, 8'h13, 2'd3);
      req = 4'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_done === 1'b0) break;
      end
      chk("rst_txlow", 32'(tx_done), 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_reset_vals("rst_mid");
      acc = 4'b0;
      repeat (15) begin
         @(negedge clk);
         acc = acc | done | ack;
      end
      chk("rst_nodone", 32'(acc), 32'h0);
      req = 4'b1111;
      wait_ack("rst_ptr", 4'b0001, 8'h10, 2'd0);
      req = 4'b0;
      wait_done("rst_ptr", 4'b0001);

`ifdef TX_ARB_TIMEOUT_EN
      // watchdog: transmitter never drops tx_done (ptr=1 -> requester 2)
      m_stuck = 1'b1;
      req = 4'b0100;
      wait_ack("to", 4'b0100, 8'h12, 2'd2);
      req = 4'b0;
      @(negedge clk);
      chk("to_en", 32'(tx_en), 32'h1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (err !== 4'b0 || done !== 4'b0) break;
      end
      chk("to_lat", 32'(n), 32'd16);
      chk("to_err", 32'(err), 32'h4);
      chk("to_done", 32'(done), 32'h0);
      chk("to_busy", 32'(busy), 32'h0);
      req = 4'b1001;
      wait_ack("to_next", 4'b1000, 8'h13, 2'd3);
      req = 4'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (err !== 4'b0 || done !== 4'b0) break;
      end
      chk("to_err2", 32'(err), 32'h8);
      m_stuck = 1'b0;
      repeat (15) @(negedge clk);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
